// File: rtl/ssd_pkg.sv
`default_nettype none
// ============================================================================
// ssd_pkg : shared constants for the seven-segment value source
// Rev 1.0
// ============================================================================
package ssd_pkg;

  localparam int            SSD_VAL_W = 14;
  localparam logic [13:0]   SSD_MAX   = 14'd9999;

  localparam logic [1:0] c_addr_value    = 2'd0;
  localparam logic [1:0] c_addr_ctrl     = 2'd1;
  localparam logic [1:0] c_addr_prescale = 2'd2;
  localparam logic [1:0] c_addr_status   = 2'd3;

  localparam int c_ctrl_run  = 0;
  localparam int c_ctrl_dir  = 1;
  localparam int c_ctrl_wrap = 2;

  function automatic logic [SSD_VAL_W-1:0] ssd_sat(input logic [SSD_VAL_W-1:0] v);
    return (v > SSD_MAX) ? SSD_MAX : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ssd_prescaler.sv
`default_nettype none
// ============================================================================
// ssd_prescaler : free-running 0..period counter, tick on terminal count
// Rev 1.0
// ============================================================================
module ssd_prescaler #(
  parameter int PRESC_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] period,
  output logic               tick
);

  logic [PRESC_W-1:0] r_pc;
  logic               w_tick;

  assign w_tick = en && (r_pc == period);
  assign tick   = w_tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= '0;
    end else if (clr || !en || w_tick) begin
      r_pc <= '0;
    end else begin
      r_pc <= r_pc + PRESC_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/ssd_value_ctrl.sv
`default_nettype none
// ============================================================================
// ssd_value_ctrl : CSR-writable 0..9999 display value with prescaled up/down count
// Rev 1.0
// ============================================================================
module ssd_value_ctrl
  import ssd_pkg::*;
#(
  parameter int ADDR_W    = 2,
  parameter int DATA_W    = 32,
  parameter int PRESC_W   = 24,
  parameter int PRESC_RST = 99_999
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iob_valid,
  input  logic [ADDR_W-1:0]   iob_addr,
  input  logic [DATA_W-1:0]   iob_wdata,
  input  logic [DATA_W/8-1:0] iob_wstrb,
  output logic                iob_ready,
  output logic [DATA_W-1:0]   iob_rdata,
  output logic                iob_rvalid,
  output logic [15:0]         data_out
);

  logic [SSD_VAL_W-1:0] r_value;
  logic                 r_run, r_dir, r_wrap;
  logic [PRESC_W-1:0]   r_presc;
  logic                 r_limit;
  logic                 r_ready;
  logic                 r_rvalid;
  logic [DATA_W-1:0]    r_rdata;

  logic w_wr, w_rd;
  logic w_wr_value, w_wr_ctrl, w_wr_presc, w_wr_status;
  logic w_tick, w_step;

  assign w_wr = iob_valid && (|iob_wstrb);
  assign w_rd = iob_valid && !(|iob_wstrb);

  assign w_wr_value  = w_wr && (iob_addr == ADDR_W'(c_addr_value));
  assign w_wr_ctrl   = w_wr && (iob_addr == ADDR_W'(c_addr_ctrl));
  assign w_wr_presc  = w_wr && (iob_addr == ADDR_W'(c_addr_prescale));
  assign w_wr_status = w_wr && (iob_addr == ADDR_W'(c_addr_status));

  // Per-bit write mask expanded from the byte strobes
  logic [PRESC_W-1:0] w_bmask;
  generate
    for (genvar gi = 0; gi < PRESC_W; gi++) begin : g_bmask
      assign w_bmask[gi] = iob_wstrb[gi/8];
    end
  endgenerate

  logic [SSD_VAL_W-1:0] w_value_merge, w_value_wr;
  logic [2:0]           w_ctrl_merge;
  logic [PRESC_W-1:0]   w_presc_merge;

  assign w_value_merge = (r_value & ~w_bmask[SSD_VAL_W-1:0]) |
                         (iob_wdata[SSD_VAL_W-1:0] & w_bmask[SSD_VAL_W-1:0]);
  assign w_value_wr    = ssd_sat(w_value_merge);
  assign w_ctrl_merge  = ({r_wrap, r_dir, r_run} & ~w_bmask[2:0]) |
                         (iob_wdata[2:0] & w_bmask[2:0]);
  assign w_presc_merge = (r_presc & ~w_bmask) | (iob_wdata[PRESC_W-1:0] & w_bmask);

  logic w_unused;
  assign w_unused = ^iob_wdata;

  ssd_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .en     (r_run),
    .clr    (w_wr_ctrl || w_wr_presc),
    .period (r_presc),
    .tick   (w_tick)
  );

  // A VALUE write in a tick cycle discards the whole step, limit effects included
  assign w_step = w_tick && !w_wr_value;

  logic [SSD_VAL_W-1:0] w_step_val;
  logic                 w_hit_lim;
  logic                 w_run_clr;

  always_comb begin
    w_step_val = r_value;
    w_hit_lim  = 1'b0;
    w_run_clr  = 1'b0;
    if (r_dir) begin
      if (r_value == '0) begin
        w_hit_lim = 1'b1;
        if (r_wrap) w_step_val = SSD_MAX;
        else        w_run_clr  = 1'b1;
      end else begin
        w_step_val = r_value - SSD_VAL_W'(1);
      end
    end else begin
      if (r_value == SSD_MAX) begin
        w_hit_lim = 1'b1;
        if (r_wrap) w_step_val = '0;
        else        w_run_clr  = 1'b1;
      end else begin
        w_step_val = r_value + SSD_VAL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_value <= '0;
      r_run   <= 1'b0;
      r_dir   <= 1'b0;
      r_wrap  <= 1'b0;
      r_presc <= PRESC_W'(PRESC_RST);
      r_limit <= 1'b0;
    end else begin
      if (w_wr_value)  r_value <= w_value_wr;
      else if (w_step) r_value <= w_step_val;

      if (w_wr_ctrl) begin
        r_run  <= w_ctrl_merge[c_ctrl_run];
        r_dir  <= w_ctrl_merge[c_ctrl_dir];
        r_wrap <= w_ctrl_merge[c_ctrl_wrap];
      end else if (w_step && w_run_clr) begin
        r_run <= 1'b0;
      end

      if (w_wr_presc) r_presc <= w_presc_merge;

      if (w_step && w_hit_lim)
        r_limit <= 1'b1;
      else if (w_wr_status && w_bmask[0] && iob_wdata[0])
        r_limit <= 1'b0;
    end
  end

  logic [DATA_W-1:0] w_rmux;

  always_comb begin
    w_rmux = '0;
    case (iob_addr)
      ADDR_W'(c_addr_value):    w_rmux = DATA_W'(r_value);
      ADDR_W'(c_addr_ctrl):     w_rmux = DATA_W'({r_wrap, r_dir, r_run});
      ADDR_W'(c_addr_prescale): w_rmux = DATA_W'(r_presc);
      ADDR_W'(c_addr_status):   w_rmux = DATA_W'(r_limit);
      default:                  w_rmux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ready  <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_ready  <= 1'b1;
      r_rvalid <= w_rd;
      if (w_rd) r_rdata <= w_rmux;
    end
  end

  assign iob_ready  = r_ready;
  assign iob_rvalid = r_rvalid;
  assign iob_rdata  = r_rdata;
  assign data_out   = {2'b00, r_value};

endmodule
`default_nettype wire

// File: tb/tb_ssd_value_ctrl.sv
`default_nettype none
// ============================================================================
// tb_ssd_value_ctrl : directed self-checking bench for ssd_value_ctrl
// Rev 1.0
// ============================================================================
module tb_ssd_value_ctrl;

  logic        clk;
  logic        rst;
  logic        iob_valid;
  logic [1:0]  iob_addr;
  logic [31:0] iob_wdata;
  logic [3:0]  iob_wstrb;
  logic        iob_ready;
  logic [31:0] iob_rdata;
  logic        iob_rvalid;
  logic [15:0] data_out;

  int n_vec = 0;
  int n_err = 0;

  ssd_value_ctrl #(
    .ADDR_W    (2),
    .DATA_W    (32),
    .PRESC_W   (24),
    .PRESC_RST (99_999)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .iob_valid  (iob_valid),
    .iob_addr   (iob_addr),
    .iob_wdata  (iob_wdata),
    .iob_wstrb  (iob_wstrb),
    .iob_ready  (iob_ready),
    .iob_rdata  (iob_rdata),
    .iob_rvalid (iob_rvalid),
    .data_out   (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Returns at the negedge right after the accepting edge
  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    iob_valid = 1'b1; iob_addr = a; iob_wdata = d; iob_wstrb = s;
    @(negedge clk);
    iob_valid = 1'b0; iob_wstrb = 4'h0; iob_wdata = 32'h0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    iob_valid = 1'b1; iob_addr = a; iob_wstrb = 4'h0;
    @(negedge clk);
    iob_valid = 1'b0;
    check({tag, "_rvalid"}, 32'(iob_rvalid), 32'd1);
    check(tag, iob_rdata, exp);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(iob_rvalid), 32'd0);
  endtask

  initial begin
    rst = 1'b0; iob_valid = 1'b0; iob_addr = 2'd0; iob_wdata = 32'h0; iob_wstrb = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_ready", 32'(iob_ready), 32'd0);
    check("rst_rvalid", 32'(iob_rvalid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(iob_ready), 32'd1);

    // Reset values of all CSRs
    rd(2'd0, 32'd0, "rd_value0");
    rd(2'd1, 32'd0, "rd_ctrl0");
    rd(2'd2, 32'd99999, "rd_presc0");
    rd(2'd3, 32'd0, "rd_status0");
    check("data_out0", 32'(data_out), 32'd0);

    // VALUE writes and saturation
    wr(2'd0, 32'd1234, 4'hF);
    check("value_1234", 32'(data_out), 32'd1234);
    wr(2'd0, 32'd12000, 4'hF);
    check("value_sat", 32'(data_out), 32'd9999);
    rd(2'd0, 32'd9999, "rd_value_sat");
    // byte 0 only: 0x270F -> 0x2705
    wr(2'd0, 32'h0000_0005, 4'b0001);
    check("value_byte0", 32'(data_out), 32'd9989);
    wr(2'd1, 32'hFFFF_FFF8, 4'hF);
    rd(2'd1, 32'd0, "rd_ctrl_unmapped");
    // byte 2 only: 0x01869F -> 0xAB869F
    wr(2'd2, 32'h00AB_0000, 4'b0100);
    rd(2'd2, 32'h00AB_869F, "rd_presc_byte2");

    // Up count with wrap, PRESCALE=3
    wr(2'd2, 32'd3, 4'hF);
    wr(2'd0, 32'd9997, 4'hF);
    wr(2'd1, 32'd5, 4'hF);
    check("wrap_start", 32'(data_out), 32'd9997);
    repeat (3) @(negedge clk);
    check("wrap_no_early", 32'(data_out), 32'd9997);
    @(negedge clk);
    check("wrap_9998", 32'(data_out), 32'd9998);
    repeat (4) @(negedge clk);
    check("wrap_9999", 32'(data_out), 32'd9999);
    repeat (4) @(negedge clk);
    check("wrap_0", 32'(data_out), 32'd0);
    rd(2'd3, 32'd1, "rd_limit_wrap");
    rd(2'd1, 32'd5, "rd_run_kept");
    wr(2'd1, 32'd0, 4'hF);
    wr(2'd3, 32'd1, 4'hF);
    rd(2'd3, 32'd0, "rd_limit_clr1");

    // Down count, no wrap, PRESCALE=0
    wr(2'd2, 32'd0, 4'hF);
    wr(2'd0, 32'd1, 4'hF);
    wr(2'd1, 32'd3, 4'hF);
    check("down_start", 32'(data_out), 32'd1);
    @(negedge clk);
    check("down_0", 32'(data_out), 32'd0);
    repeat (3) @(negedge clk);
    check("down_hold", 32'(data_out), 32'd0);
    rd(2'd1, 32'd2, "rd_run_cleared");
    rd(2'd3, 32'd1, "rd_limit_down");
    wr(2'd3, 32'd1, 4'hF);
    rd(2'd3, 32'd0, "rd_limit_clr2");

    // VALUE write collides with a tick
    wr(2'd0, 32'd100, 4'hF);
    wr(2'd1, 32'd1, 4'hF);
    check("up_100", 32'(data_out), 32'd100);
    @(negedge clk);
    check("up_101", 32'(data_out), 32'd101);
    wr(2'd0, 32'd500, 4'hF);
    check("collide_500", 32'(data_out), 32'd500);
    @(negedge clk);
    check("collide_501", 32'(data_out), 32'd501);
    @(negedge clk);
    check("collide_502", 32'(data_out), 32'd502);
    wr(2'd1, 32'd0, 4'hF);

    // Asynchronous reset mid-count, PRESCALE=2
    wr(2'd2, 32'd2, 4'hF);
    wr(2'd0, 32'd10, 4'hF);
    rd(2'd0, 32'd10, "rd_value10");
    wr(2'd1, 32'd1, 4'hF);
    repeat (7) @(negedge clk);
    check("presc2_12", 32'(data_out), 32'd12);
    #2 rst = 1'b0;
    #1;
    check("arst_data_out", 32'(data_out), 32'd0);
    check("arst_ready", 32'(iob_ready), 32'd0);
    check("arst_rvalid", 32'(iob_rvalid), 32'd0);
    check("arst_rdata", iob_rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rel_ready", 32'(iob_ready), 32'd1);
    repeat (6) @(negedge clk);
    check("rel_no_step", 32'(data_out), 32'd0);
    rd(2'd1, 32'd0, "rd_ctrl_rst");
    rd(2'd2, 32'd99999, "rd_presc_rst");
    rd(2'd0, 32'd0, "rd_value_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
